gmii_tx_sched: RTL and testbench

- Read-side sequencer for the 72-bit XGMII→GMII async FIFO, in the gmii_clk domain.
- Pops {txc[7:0], txd[63:0]} words only when a complete frame is queued. Serializes lane 0 first onto GMII with preamble/SFD regeneration.
- Enforces inter-frame gap, drops stray idle words, flags underrun/error.
- Replaces the unused read-side logic of the XGMII→GMII converter.

---
 rtl/gmii_tx_sched_if.sv | 27 ++
 rtl/gmii_tx_sched.sv | 180 ++++++++++++++++++
 tb/tb_gmii_tx_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_sched_if.sv
// FIFO read side and GMII transmit side of the XGMII->GMII scheduler.
// master = scheduler, slave = FIFO/PHY side.
interface gmii_tx_sched_if #(
    parameter int CNT_W = 8
);
    logic [71:0]      fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [CNT_W-1:0] pkt_wr_cnt;
    logic [CNT_W-1:0] pkt_rd_cnt;
    logic             gmii_en;
    logic             gmii_er;
    logic [7:0]       gmii_txd;
    logic             underrun;

    modport master (
        input  fifo_dout, fifo_empty, pkt_wr_cnt,
        output fifo_rd_en, pkt_rd_cnt,
        output gmii_en, gmii_er, gmii_txd, underrun
    );

    modport slave (
        output fifo_dout, fifo_empty, pkt_wr_cnt,
        input  fifo_rd_en, pkt_rd_cnt,
        input  gmii_en, gmii_er, gmii_txd, underrun
    );
endinterface

// File: rtl/gmii_tx_sched.sv
// Read-side sequencer: pops whole XGMII frames from the async FIFO
// and serializes them lane 0 first onto GMII with preamble and IFG.
module gmii_tx_sched #(
    parameter int IFG_BYTES = 12,
    parameter int CNT_W     = 8
) (
    input logic             gmii_clk,
    input logic             sys_rst_n,
    gmii_tx_sched_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH, CHECK, SEND, DROP, IFG
    } state_t;

    localparam logic [8:0] IFG_W   = 9'(IFG_BYTES);
    localparam logic [7:0] IFG_RST = 8'(IFG_BYTES);

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [71:0]      wbuf, wbuf_n;
    logic             sof, sof_n;
    logic             uf, uf_n;
    logic             chk, chk_n;
    logic [7:0]       ifg, ifg_n;
    logic             rd_en, rd_en_n;
    logic             en, en_n;
    logic             er, er_n;
    logic             urun, urun_n;
    logic [7:0]       txd, txd_n;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_n;

    logic [7:0] txc, lane, ifg_inc;
    logic       lc, lead, term, term_hi;
    logic       frame_q, dout_fd, gap_ok, gap_near;

    function automatic logic has_fd(input logic [71:0] w);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 8; i++)
            if (w[64+i] && w[i*8 +: 8] == 8'hFD) f = 1'b1;
        return f;
    endfunction

    assign txc     = wbuf[71:64];
    assign lane    = wbuf[{1'b0, idx, 3'b000} +: 8];
    assign lc      = txc[idx];
    assign lead    = sof && (idx == 3'd0);
    assign term    = lc && !lead && (lane != 8'hFE);
    assign term_hi = (txc[5] && wbuf[47:40] != 8'hFE)
                  || (txc[6] && wbuf[55:48] != 8'hFE)
                  || (txc[7] && wbuf[63:56] != 8'hFE);
    assign frame_q = bus.pkt_wr_cnt != rd_cnt;
    assign dout_fd = has_fd(bus.fifo_dout);
    assign ifg_inc = (ifg == 8'hFF) ? ifg : ifg + 8'd1;

    // Pop->preamble takes 3 cycles plus the FD cycle, so the gap
    // seen on the wire is the counter value plus 4.
    assign gap_ok   = ({1'b0, ifg} + 9'd4) >= IFG_W;
    assign gap_near = ({1'b0, ifg} + 9'd5) >= IFG_W;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        wbuf_n   = wbuf;
        sof_n    = sof;
        uf_n     = uf;
        chk_n    = chk;
        ifg_n    = ifg_inc;
        rd_cnt_n = rd_cnt;
        rd_en_n  = 1'b0;
        en_n     = 1'b0;
        er_n     = 1'b0;
        txd_n    = 8'h00;
        urun_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_q && !bus.fifo_empty && gap_ok) begin
                    rd_en_n = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = CHECK;
            CHECK: begin
                if (bus.fifo_dout[71:64] == 8'h01 &&
                    bus.fifo_dout[7:0] == 8'hFB) begin
                    wbuf_n  = bus.fifo_dout;
                    idx_n   = 3'd0;
                    sof_n   = 1'b1;
                    uf_n    = 1'b0;
                    state_n = SEND;
                end else begin
                    state_n = IDLE;
                end
            end
            SEND: begin
                idx_n = idx + 3'd1;
                sof_n = 1'b0;
                if (uf && idx == 3'd7) begin
                    en_n    = 1'b1;
                    er_n    = 1'b1;
                    urun_n  = 1'b1;
                    chk_n   = 1'b0;
                    state_n = DROP;
                end else if (term) begin
                    rd_cnt_n = rd_cnt + CNT_W'(1);
                    ifg_n    = 8'h00;
                    state_n  = IFG;
                end else begin
                    en_n  = 1'b1;
                    txd_n = lead ? 8'h55 : lane;
                    er_n  = lc && !lead;
                    if (idx == 3'd5 && !term_hi) begin
                        if (bus.fifo_empty) uf_n = 1'b1;
                        else rd_en_n = 1'b1;
                    end
                    if (idx == 3'd7) wbuf_n = bus.fifo_dout;
                end
            end
            DROP: begin
                if (rd_en) begin
                    chk_n = 1'b1;
                end else if (chk) begin
                    chk_n = 1'b0;
                    if (dout_fd) begin
                        rd_cnt_n = rd_cnt + CNT_W'(1);
                        ifg_n    = 8'h00;
                        state_n  = IFG;
                    end else if (!bus.fifo_empty) begin
                        rd_en_n = 1'b1;
                    end
                end else if (!bus.fifo_empty) begin
                    rd_en_n = 1'b1;
                end
            end
            IFG: begin
                if (gap_near) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            idx    <= 3'd0;
            wbuf   <= '0;
            sof    <= 1'b0;
            uf     <= 1'b0;
            chk    <= 1'b0;
            ifg    <= IFG_RST;
            rd_cnt <= '0;
            rd_en  <= 1'b0;
            en     <= 1'b0;
            er     <= 1'b0;
            txd    <= 8'h00;
            urun   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            wbuf   <= wbuf_n;
            sof    <= sof_n;
            uf     <= uf_n;
            chk    <= chk_n;
            ifg    <= ifg_n;
            rd_cnt <= rd_cnt_n;
            rd_en  <= rd_en_n;
            en     <= en_n;
            er     <= er_n;
            txd    <= txd_n;
            urun   <= urun_n;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.pkt_rd_cnt = rd_cnt;
    assign bus.gmii_en    = en;
    assign bus.gmii_er    = er;
    assign bus.gmii_txd   = txd;
    assign bus.underrun   = urun;
endmodule

// File: tb/tb_gmii_tx_sched.sv
// Bench for gmii_tx_sched: FIFO model, GMII scoreboard, frame table
// plus directed back-to-back, idle, underrun, wrap and reset cases.
module tb_gmii_tx_sched;
    logic clk = 1'b0;
    logic rst_n;

    gmii_tx_sched_if #(.CNT_W(8)) bus ();

    gmii_tx_sched #(.IFG_BYTES(12), .CNT_W(8)) dut (
        .gmii_clk (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    initial forever #4 clk = ~clk;

    typedef struct {
        int n;
        int fe;
    } vec_t;

    vec_t        vecs[5];
    logic [71:0] fq[$];
    logic [71:0] stage[$];
    logic [8:0]  expq[$];
    int          checks, passes;
    int          cyc, ur_cnt, last_gap, idle_run;
    int          arm_req, arm_ack, t_rd, t_en;
    logic        t_wait, prev_en, rd_prev;
    logic [7:0]  wr;

    task automatic chk(input string name, input longint act,
                       input longint exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    endtask

    task automatic build(input int n, input int fe);
        logic [63:0] d;
        logic [7:0]  c;
        logic [7:0]  b;
        int          ln;
        stage.push_back({8'h01, 8'hD5, {6{8'h55}}, 8'hFB});
        for (int k = 0; k < 7; k++) expq.push_back({1'b0, 8'h55});
        expq.push_back({1'b0, 8'hD5});
        d  = '0;
        c  = '0;
        ln = 0;
        for (int i = 0; i < n; i++) begin
            if (i == fe) begin
                b     = 8'hFE;
                c[ln] = 1'b1;
                expq.push_back({1'b1, 8'hFE});
            end else begin
                b = 8'($urandom);
                expq.push_back({1'b0, b});
            end
            d[ln*8 +: 8] = b;
            ln++;
            if (ln == 8) begin
                stage.push_back({c, d});
                d  = '0;
                c  = '0;
                ln = 0;
            end
        end
        d[ln*8 +: 8] = 8'hFD;
        c[ln]        = 1'b1;
        for (int k = ln + 1; k < 8; k++) begin
            d[k*8 +: 8] = 8'h07;
            c[k]        = 1'b1;
        end
        stage.push_back({c, d});
    endtask

    task automatic move(input int k);
        for (int i = 0; i < k; i++) fq.push_back(stage.pop_front());
    endtask

    task automatic wait_rd(input logic [7:0] tgt, input int budget,
                           input string name);
        int i;
        i = 0;
        while (bus.pkt_rd_cnt != tgt && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk(name, bus.pkt_rd_cnt, tgt);
        repeat (20) @(posedge clk);
        #1;
        chk({name, "_drain"}, expq.size(), 0);
    endtask

    initial begin
        int ur0;
        int i;
        rst_n          = 1'b0;
        wr             = 8'h00;
        bus.pkt_wr_cnt = 8'h00;
        bus.fifo_dout  <= '0;
        bus.fifo_empty = 1'b1;
        checks = 0; passes = 0; cyc = 0; ur_cnt = 0;
        last_gap = 0; idle_run = 0; arm_req = 0; arm_ack = 0;
        t_rd = 0; t_en = 0; t_wait = 1'b0;
        prev_en = 1'b0; rd_prev = 1'b0;
        vecs[0] = '{64, -1};
        vecs[1] = '{45, -1};
        vecs[2] = '{20, 9};
        vecs[3] = '{8, -1};
        vecs[4] = '{13, 3};

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (arm_req != arm_ack && bus.fifo_rd_en) begin
                    arm_ack = arm_req;
                    t_rd    = cyc;
                    t_wait  = 1'b1;
                end
                if (t_wait && bus.gmii_en) begin
                    t_en   = cyc;
                    t_wait = 1'b0;
                end
                if (bus.gmii_en) begin
                    if (!prev_en) last_gap = idle_run;
                    idle_run = 0;
                    if (expq.size() == 0) begin
                        checks++;
                        $display("FAIL gmii_extra: got en=1 txd=%h want en=0",
                                 bus.gmii_txd);
                    end else begin
                        chk("gmii_byte", {bus.gmii_er, bus.gmii_txd},
                            expq.pop_front());
                    end
                end else begin
                    idle_run++;
                end
                prev_en = bus.gmii_en;
                if (bus.underrun) begin
                    ur_cnt++;
                    chk("underrun_byte",
                        {bus.gmii_en, bus.gmii_er, bus.gmii_txd}, 10'h300);
                end
                bus.fifo_empty = (fq.size() == 0);
            end
            forever begin
                @(posedge clk);
                if (bus.fifo_rd_en) begin
                    chk("rd_en_legal", (fq.size() > 0) && !rd_prev, 1);
                    if (fq.size() > 0) bus.fifo_dout <= fq.pop_front();
                end
                rd_prev = bus.fifo_rd_en;
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", bus.gmii_en, 0);
        chk("rst_er", bus.gmii_er, 0);
        chk("rst_txd", bus.gmii_txd, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_rd_cnt", bus.pkt_rd_cnt, 0);
        chk("rst_underrun", bus.underrun, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            arm_req++;
            build(vecs[v].n, vecs[v].fe);
            move(stage.size());
            wr++;
            bus.pkt_wr_cnt = wr;
            wait_rd(wr, 400, "vec_rd_cnt");
            chk("vec_latency", t_en - t_rd, 3);
        end

        build(16, -1);
        build(24, -1);
        move(stage.size());
        wr += 8'd2;
        bus.pkt_wr_cnt = wr;
        wait_rd(wr, 400, "b2b_rd_cnt");
        chk("b2b_gap", last_gap, 12);

        stage.push_back({8'hFF, {8{8'h07}}});
        build(8, -1);
        move(stage.size());
        wr++;
        bus.pkt_wr_cnt = wr;
        wait_rd(wr, 400, "idle_rd_cnt");
        chk("idle_fifo_empty", fq.size(), 0);

        ur0 = ur_cnt;
        build(40, -1);
        while (expq.size() > 31) void'(expq.pop_back());
        expq.push_back(9'h100);
        move(4);
        wr++;
        bus.pkt_wr_cnt = wr;
        i = 0;
        while (ur_cnt == ur0 && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("underrun_pulse", ur_cnt - ur0, 1);
        repeat (10) @(posedge clk);
        #1;
        move(stage.size());
        wait_rd(wr, 400, "ur_rd_cnt");
        chk("ur_fifo_empty", fq.size(), 0);

        while (wr != 8'hFF) begin
            build(1, -1);
            wr++;
        end
        move(stage.size());
        bus.pkt_wr_cnt = wr;
        wait_rd(8'hFF, 20000, "wrap_ff");
        build(3, -1);
        move(stage.size());
        wr++;
        bus.pkt_wr_cnt = wr;
        wait_rd(8'h00, 400, "wrap_00");

        build(64, -1);
        move(stage.size());
        wr++;
        bus.pkt_wr_cnt = wr;
        i = 0;
        while (!bus.gmii_en && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("mid_en_seen", bus.gmii_en, 1);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", bus.gmii_en, 0);
        chk("mid_rst_er", bus.gmii_er, 0);
        chk("mid_rst_rd_cnt", bus.pkt_rd_cnt, 0);
        chk("mid_rst_rd_en", bus.fifo_rd_en, 0);
        expq.delete();
        fq.delete();
        stage.delete();
        wr = 8'h00;
        bus.pkt_wr_cnt = wr;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        arm_req++;
        build(8, -1);
        move(stage.size());
        wr++;
        bus.pkt_wr_cnt = wr;
        wait_rd(wr, 400, "post_rst_rd_cnt");
        chk("post_rst_latency", t_en - t_rd, 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
